// File: rtl/riscv_lsu.sv
// riscv_lsu: single-access load/store unit between the ALU stage and the data-memory bus.
// Define RISCV_LSU_TIMEOUT_EN to abort accesses that stall longer than TIMEOUT_CYCLES.
module riscv_lsu #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mem_req_i,
   input  logic        mem_wr_i,
   input  logic [1:0]  mem_size_i,
   input  logic        mem_zext_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        lsu_stall_o,
   output logic        lsu_done_o,
   output logic [31:0] ld_data_o,
   output logic        misalign_o,
   output logic        bus_err_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i
);
   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;
   state_e      state_q;
   logic [1:0]  off_q, size_q;
   logic        zext_q, done_q, misalign_q, dmem_req_q, dmem_we_q;
   logic [31:0] dmem_addr_q, dmem_wdata_q, ld_data_q;
   logic [3:0]  dmem_be_q;
   logic        legal, tmo;
   logic [3:0]  be_c;
   logic [31:0] wdata_c, sh_c, ext_c;

   assign legal   = mem_size_i == 2'b00 || (mem_size_i == 2'b01 && !addr_i[0]) ||
                    (mem_size_i == 2'b10 && addr_i[1:0] == 2'b00);
   assign be_c    = mem_size_i == 2'b00 ? 4'b0001 << addr_i[1:0] :
                    mem_size_i == 2'b01 ? 4'b0011 << addr_i[1:0] : 4'b1111;
   assign wdata_c = mem_size_i == 2'b00 ? {4{wdata_i[7:0]}} :
                    mem_size_i == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
   assign sh_c    = dmem_rdata_i >> {off_q, 3'b000};
   assign ext_c   = size_q == 2'b00 ? {{24{sh_c[7] & ~zext_q}}, sh_c[7:0]} :
                    size_q == 2'b01 ? {{16{sh_c[15] & ~zext_q}}, sh_c[15:0]} : sh_c;

`ifdef RISCV_LSU_TIMEOUT_EN
   localparam int CW = TIMEOUT_CYCLES > 255 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CW-1:0] cnt_q;
   logic          bus_err_q;
   assign tmo       = cnt_q == CW'(TIMEOUT_CYCLES - 1);
   assign bus_err_o = bus_err_q;
   // Counter rests at zero in IDLE/DONE so every REQ entry starts a fresh budget.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         bus_err_q <= 1'b0;
      end else begin
         cnt_q     <= (state_q == REQ || state_q == RESP) ? cnt_q + 1'b1 : '0;
         bus_err_q <= tmo && ((state_q == REQ && !dmem_gnt_i) || (state_q == RESP && !dmem_rvalid_i));
      end
   end
`else
   assign tmo       = 1'b0;
   assign bus_err_o = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         off_q        <= '0;
         size_q       <= '0;
         zext_q       <= 1'b0;
         done_q       <= 1'b0;
         misalign_q   <= 1'b0;
         ld_data_q    <= '0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= '0;
         dmem_be_q    <= '0;
         dmem_wdata_q <= '0;
      end else begin
         done_q     <= 1'b0;
         misalign_q <= 1'b0;
         case (state_q)
            IDLE: if (mem_req_i) begin
               off_q  <= addr_i[1:0];
               size_q <= mem_size_i;
               zext_q <= mem_zext_i;
               if (legal) begin
                  state_q      <= REQ;
                  dmem_req_q   <= 1'b1;
                  dmem_we_q    <= mem_wr_i;
                  dmem_addr_q  <= {addr_i[31:2], 2'b00};
                  dmem_be_q    <= be_c;
                  dmem_wdata_q <= wdata_c;
               end else begin
                  state_q    <= DONE;
                  done_q     <= 1'b1;
                  misalign_q <= 1'b1;
                  ld_data_q  <= '0;
               end
            end
            REQ: if (dmem_gnt_i || tmo) begin
               dmem_req_q   <= 1'b0;
               dmem_we_q    <= 1'b0;
               dmem_addr_q  <= '0;
               dmem_be_q    <= '0;
               dmem_wdata_q <= '0;
               state_q      <= (dmem_gnt_i && !dmem_we_q) ? RESP : DONE;
               if (!dmem_gnt_i || dmem_we_q) begin
                  done_q    <= 1'b1;
                  ld_data_q <= '0;
               end
            end
            RESP: if (dmem_rvalid_i || tmo) begin
               state_q   <= DONE;
               done_q    <= 1'b1;
               ld_data_q <= dmem_rvalid_i ? ext_c : '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign lsu_stall_o  = (state_q == IDLE && mem_req_i) || state_q == REQ || state_q == RESP;
   assign lsu_done_o   = done_q;
   assign misalign_o   = misalign_q;
   assign ld_data_o    = ld_data_q;
   assign dmem_req_o   = dmem_req_q;
   assign dmem_we_o    = dmem_we_q;
   assign dmem_addr_o  = dmem_addr_q;
   assign dmem_be_o    = dmem_be_q;
   assign dmem_wdata_o = dmem_wdata_q;
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed self-checking bench for the load/store unit.
module tb_riscv_lsu;
`ifdef RISCV_LSU_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif
   logic        clk_i = 1'b0, rst_i = 1'b1;
   logic        mem_req_i = 1'b0, mem_wr_i = 1'b0, mem_zext_i = 1'b0;
   logic [1:0]  mem_size_i = '0;
   logic [31:0] addr_i = '0, wdata_i = '0;
   logic        lsu_stall_o, lsu_done_o, misalign_o, bus_err_o;
   logic [31:0] ld_data_o;
   logic        dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o, dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
   logic [31:0] dmem_rdata_i = '0;

   int checks = 0, errors = 0;
   int n_stall, n_req, n_done, done_cyc;
   logic [3:0]  r_be;
   logic [31:0] r_wd, r_ad, r_ld;
   logic        r_we, r_mis, r_err;

   riscv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .mem_req_i(mem_req_i), .mem_wr_i(mem_wr_i),
      .mem_size_i(mem_size_i), .mem_zext_i(mem_zext_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .lsu_stall_o(lsu_stall_o), .lsu_done_o(lsu_done_o), .ld_data_o(ld_data_o),
      .misalign_o(misalign_o), .bus_err_o(bus_err_o), .dmem_req_o(dmem_req_o),
      .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
      .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
      .dmem_rdata_i(dmem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   // Cycle 0 is the accept cycle; gnt arrives in the (gdly+1)-th request cycle, rvalid immediately.
   task automatic run_txn(input logic wr, input logic [1:0] sz, input logic z, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int gdly, input int maxc);
      n_stall = 0; n_req = 0; n_done = 0; done_cyc = -1;
      r_be = '0; r_wd = '0; r_ad = '0; r_ld = '0; r_we = 1'b0; r_mis = 1'b0; r_err = 1'b0;
      @(negedge clk_i);
      mem_req_i = 1'b1; mem_wr_i = wr; mem_size_i = sz; mem_zext_i = z;
      addr_i = a; wdata_i = wd; dmem_rdata_i = rd;
      for (int c = 0; c < maxc; c++) begin
         #1;
         if (lsu_stall_o) n_stall++;
         dmem_gnt_i = 1'b0;
         dmem_rvalid_i = 1'b0;
         if (dmem_req_o) begin
            n_req++;
            r_be = dmem_be_o; r_wd = dmem_wdata_o; r_ad = dmem_addr_o; r_we = dmem_we_o;
            dmem_gnt_i = n_req > gdly;
         end else if (c > 0 && lsu_stall_o) dmem_rvalid_i = 1'b1;
         if (lsu_done_o) begin
            n_done++;
            if (done_cyc < 0) done_cyc = c;
            r_ld = ld_data_o; r_mis = misalign_o; r_err = bus_err_o;
            mem_req_i = 1'b0;
         end
         if (done_cyc >= 0 && c >= done_cyc + 2) break;
         @(negedge clk_i);
      end
      mem_req_i = 1'b0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
   endtask

   task automatic test_reset;
      #2;
      checks++;
      if ({lsu_stall_o, lsu_done_o, misalign_o, bus_err_o, dmem_req_o, dmem_we_o} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 000000", {lsu_stall_o, lsu_done_o, misalign_o, bus_err_o, dmem_req_o, dmem_we_o});
      end
      checks++;
      if ({ld_data_o, dmem_addr_o, dmem_wdata_o, dmem_be_o} !== 100'b0) begin
         errors++;
         $display("FAIL reset_data got ld=%h addr=%h wd=%h be=%b want all 0", ld_data_o, dmem_addr_o, dmem_wdata_o, dmem_be_o);
      end
      @(negedge clk_i); @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic test_lb;
      run_txn(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 20);
      checks++; if (r_be !== 4'b1000) begin errors++; $display("FAIL lb_be got %b want 1000", r_be); end
      checks++; if (r_ad !== 32'h0000_1000) begin errors++; $display("FAIL lb_addr got %h want 00001000", r_ad); end
      checks++; if (r_ld !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h want ffffff80", r_ld); end
      checks++; if (done_cyc !== 3 || n_done !== 1) begin errors++; $display("FAIL lb_done got cyc=%0d n=%0d want cyc=3 n=1", done_cyc, n_done); end
      checks++; if (n_stall !== 3 || r_we !== 1'b0) begin errors++; $display("FAIL lb_stall got stall=%0d we=%b want 3 0", n_stall, r_we); end
   endtask

   task automatic test_lhu_lh;
      run_txn(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 0, 20);
      checks++; if (r_be !== 4'b1100) begin errors++; $display("FAIL lhu_be got %b want 1100", r_be); end
      checks++; if (r_ld !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_data got %h want 0000beef", r_ld); end
      run_txn(1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0, 32'h8001_0000, 0, 20);
      checks++; if (r_ld !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_data got %h want ffff8001", r_ld); end
      run_txn(1'b0, 2'b00, 1'b1, 32'h0000_0001, 32'h0, 32'h0000_9A00, 0, 20);
      checks++; if (r_ld !== 32'h0000_009A || r_be !== 4'b0010) begin errors++; $display("FAIL lbu_data got %h be=%b want 0000009a 0010", r_ld, r_be); end
   endtask

   task automatic test_lw;
      run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 20);
      checks++; if (r_be !== 4'b1111 || r_ld !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw got be=%b ld=%h want 1111 deadbeef", r_be, r_ld); end
      checks++; if (ld_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_hold got %h want deadbeef", ld_data_o); end
   endtask

   task automatic test_store;
      run_txn(1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h1234_ABCD, 32'h0, 3, 30);
      checks++; if (n_req !== 4) begin errors++; $display("FAIL sh_req_cycles got %0d want 4", n_req); end
      checks++; if (r_be !== 4'b1100 || r_wd !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_lane got be=%b wd=%h want 1100 abcdabcd", r_be, r_wd); end
      checks++; if (n_stall !== 5 || n_done !== 1 || done_cyc !== 5) begin errors++; $display("FAIL sh_timing got stall=%0d n=%0d cyc=%0d want 5 1 5", n_stall, n_done, done_cyc); end
      checks++; if (r_we !== 1'b1 || r_ad !== 32'h0000_0004 || r_ld !== 32'h0) begin errors++; $display("FAIL sh_misc got we=%b addr=%h ld=%h want 1 00000004 0", r_we, r_ad, r_ld); end
      run_txn(1'b1, 2'b00, 1'b0, 32'h0000_0001, 32'h0000_005A, 32'h0, 0, 20);
      checks++; if (r_be !== 4'b0010 || r_wd !== 32'h5A5A_5A5A || done_cyc !== 2 || n_stall !== 2) begin
         errors++; $display("FAIL sb got be=%b wd=%h cyc=%0d stall=%0d want 0010 5a5a5a5a 2 2", r_be, r_wd, done_cyc, n_stall);
      end
   endtask

   task automatic test_misalign;
      run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0005, 32'h0, 32'h1111_1111, 0, 20);
      checks++; if (n_req !== 0 || r_mis !== 1'b1 || done_cyc !== 1 || n_stall !== 1 || r_ld !== 32'h0) begin
         errors++; $display("FAIL lw_misalign got req=%0d mis=%b cyc=%0d stall=%0d ld=%h want 0 1 1 1 0", n_req, r_mis, done_cyc, n_stall, r_ld);
      end
      run_txn(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 32'h1111_1111, 0, 20);
      checks++; if (n_req !== 0 || r_mis !== 1'b1 || done_cyc !== 1) begin errors++; $display("FAIL size11 got req=%0d mis=%b cyc=%0d want 0 1 1", n_req, r_mis, done_cyc); end
      run_txn(1'b1, 2'b01, 1'b0, 32'h0000_0003, 32'h0, 32'h0, 0, 20);
      checks++; if (n_req !== 0 || r_mis !== 1'b1) begin errors++; $display("FAIL sh_misalign got req=%0d mis=%b want 0 1", n_req, r_mis); end
      checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL misalign_pulse got %b want 0", misalign_o); end
   endtask

   task automatic test_reset_in_resp;
      logic bad_done;
      run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0, 32'h7777_0001, 0, 20);
      @(negedge clk_i);
      mem_req_i = 1'b1; mem_wr_i = 1'b0; mem_size_i = 2'b10; addr_i = 32'h0000_0300;
      @(negedge clk_i); #1 dmem_gnt_i = 1'b1;
      @(negedge clk_i); dmem_gnt_i = 1'b0;
      #1;
      checks++; if (lsu_stall_o !== 1'b1 || dmem_req_o !== 1'b0) begin errors++; $display("FAIL rst_pre_resp got stall=%b req=%b want 1 0", lsu_stall_o, dmem_req_o); end
      rst_i = 1'b1; mem_req_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
      #1;
      checks++; if ({lsu_stall_o, lsu_done_o, dmem_req_o} !== 3'b0 || ld_data_o !== 32'h0) begin
         errors++; $display("FAIL rst_async got stall=%b done=%b req=%b ld=%h want 0 0 0 0", lsu_stall_o, lsu_done_o, dmem_req_o, ld_data_o);
      end
      @(negedge clk_i); rst_i = 1'b0;
      bad_done = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1 if (lsu_done_o !== 1'b0 || ld_data_o !== 32'h0 || lsu_stall_o !== 1'b0) bad_done = 1'b1;
         @(negedge clk_i);
      end
      dmem_rvalid_i = 1'b0;
      checks++; if (bad_done !== 1'b0) begin errors++; $display("FAIL rst_late_rvalid got activity=%b want 0", bad_done); end
      run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h0BAD_F00D, 0, 20);
      checks++; if (done_cyc !== 3 || r_ld !== 32'h0BAD_F00D) begin errors++; $display("FAIL rst_recover got cyc=%0d ld=%h want 3 0badf00d", done_cyc, r_ld); end
   endtask

   task automatic test_stall_hold;
      run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0, 32'h1234_5678, 1000, 30);
`ifdef RISCV_LSU_TIMEOUT_EN
      checks++; if (n_done !== 1 || done_cyc !== 5 || r_err !== 1'b1) begin errors++; $display("FAIL timeout got n=%0d cyc=%0d err=%b want 1 5 1", n_done, done_cyc, r_err); end
      checks++; if (n_req !== 4 || r_ld !== 32'h0) begin errors++; $display("FAIL timeout_req got req=%0d ld=%h want 4 0", n_req, r_ld); end
`else
      checks++; if (n_done !== 0 || n_stall !== 30 || n_req !== 29) begin errors++; $display("FAIL stall_hold got n=%0d stall=%0d req=%0d want 0 30 29", n_done, n_stall, n_req); end
      checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL bus_err_tie got %b want 0", bus_err_o); end
`endif
      rst_i = 1'b1;
      #3 rst_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_lb();
      test_lhu_lh();
      test_lw();
      test_store();
      test_misalign();
      test_reset_in_resp();
      test_stall_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
